// File: rtl/rr_arb_mux.sv
// rr_arb_mux: registered N-to-1 data selector. A round-robin arbiter picks
// one valid producer per cycle and loads its word into a single output
// register. A forced-select mode falls back to fixed-channel muxing.
//
// Handshake: a word moves across an interface on a clock edge where both
// valid and ready are high. Producers hold in_valid/in_data until accepted
// and must not derive in_valid from in_ready. out_valid/out_data/out_sel
// stay stable while out_valid=1 and out_ready=0. in_ready is one-hot or
// zero and may follow out_ready combinationally.
module rr_arb_mux #(
  parameter  int WIDTH = 32,
  parameter  int N     = 4,
  localparam int SELW  = $clog2(N)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [N*WIDTH-1:0]   in_data,
  input  logic [N-1:0]         in_valid,
  output logic [N-1:0]         in_ready,
  input  logic                 force_en,
  input  logic [SELW-1:0]      force_sel,
  output logic [WIDTH-1:0]     out_data,
  output logic [SELW-1:0]      out_sel,
  output logic                 out_valid,
  input  logic                 out_ready
);

  logic [SELW-1:0]  ptr;
  logic [SELW-1:0]  grant_idx;
  logic             grant_vld;
  logic [SELW-1:0]  idx;
  logic             load_en;
  logic [WIDTH-1:0] chan [N];
  logic [WIDTH-1:0] sel_data;

  // Split the flat input bus into per-channel words.
  for (genvar i = 0; i < N; i++) begin : g_chan
    assign chan[i] = in_data[i*WIDTH +: WIDTH];
  end

  // The output register may take a new word when empty or being drained.
  assign load_en  = ~out_valid | out_ready;
  assign sel_data = chan[grant_idx];

  // Arbitration: forced channel only, or first valid channel from ptr upward.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    idx       = '0;
    if (force_en) begin
      // Compare against every legal index so an out-of-range force_sel
      // simply matches nothing.
      for (int i = 0; i < N; i++) begin
        if (force_sel == SELW'(i) && in_valid[i]) begin
          grant_vld = 1'b1;
          grant_idx = SELW'(i);
        end
      end
    end else begin
      // Walk offsets from far to near so the nearest valid channel wins.
      for (int k = N - 1; k >= 0; k--) begin
        idx = SELW'((int'(ptr) + k) % N);
        if (in_valid[idx]) begin
          grant_vld = 1'b1;
          grant_idx = idx;
        end
      end
    end
  end

  // Accept strobe for the granted channel; silent while reset is asserted.
  always_comb begin
    in_ready = '0;
    if (reset && grant_vld && load_en) begin
      in_ready[grant_idx] = 1'b1;
    end
  end

  // Output register and round-robin pointer.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sel   <= '0;
      ptr       <= '0;
    end else if (load_en) begin
      if (grant_vld) begin
        out_valid <= 1'b1;
        out_data  <= sel_data;
        out_sel   <= grant_idx;
        if (!force_en) begin
          ptr <= (grant_idx == SELW'(N - 1)) ? '0 : grant_idx + SELW'(1);
        end
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_rr_arb_mux.sv
// Bench for rr_arb_mux: directed scenarios followed by randomized traffic,
// all compared against a queue-based reference model.
module tb_rr_arb_mux;

  localparam int WIDTH = 32;
  localparam int N     = 4;
  localparam int SELW  = 2;

  logic               clk = 1'b0;
  logic               reset;
  logic [N*WIDTH-1:0] in_data;
  logic [N-1:0]       in_valid;
  logic [N-1:0]       in_ready;
  logic               force_en;
  logic [SELW-1:0]    force_sel;
  logic [WIDTH-1:0]   out_data;
  logic [SELW-1:0]    out_sel;
  logic               out_valid;
  logic               out_ready;

  rr_arb_mux #(.WIDTH(WIDTH), .N(N)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .force_en  (force_en),
    .force_sel (force_sel),
    .out_data  (out_data),
    .out_sel   (out_sel),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  // Clock: 10 time-unit period.
  always #5 clk = ~clk;

  // Reference model: words accepted but not yet drained, plus pointer.
  logic [WIDTH-1:0] exp_q[$];
  int               sel_q[$];
  int               m_ptr;
  logic [WIDTH-1:0] last_data;
  int               last_sel;
  logic [N-1:0]     ir_seen;
  int               checks = 0;
  int               errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    sel_q.delete();
    m_ptr     = 0;
    last_data = '0;
    last_sel  = 0;
  endtask

  // Grant rule: forced channel if valid, else first valid at ptr, ptr+1, ...
  function automatic int model_grant(input logic [N-1:0] vld, input logic fen,
                                     input int fsel, input int ptr);
    if (fen) begin
      if (fsel < N) begin
        if (vld[fsel]) return fsel;
      end
      return -1;
    end
    for (int k = 0; k < N; k++) begin
      int c;
      c = (ptr + k) % N;
      if (vld[c]) return c;
    end
    return -1;
  endfunction

  task automatic check_outputs();
    check("out_valid", out_valid, exp_q.size() > 0);
    if (exp_q.size() > 0) begin
      check("out_data", out_data, exp_q[0]);
      check("out_sel", out_sel, sel_q[0]);
    end else begin
      check("hold_data", out_data, last_data);
      check("hold_sel", out_sel, last_sel);
    end
  endtask

  // One clock: drive at negedge, check in_ready, update model at posedge,
  // check registered outputs just after.
  task automatic cycle(input logic rst, input logic [N-1:0] vld, input logic rdy,
                       input logic fen, input logic [SELW-1:0] fsel);
    int           g;
    logic         load;
    logic [N-1:0] exp_ir;
    @(negedge clk);
    reset     = rst;
    in_valid  = vld;
    out_ready = rdy;
    force_en  = fen;
    force_sel = fsel;
    g      = model_grant(vld, fen, int'(fsel), m_ptr);
    load   = (exp_q.size() == 0) || rdy;
    exp_ir = '0;
    if (rst && load && g >= 0) exp_ir[g] = 1'b1;
    #1;
    ir_seen = in_ready;
    check("in_ready", in_ready, exp_ir);
    @(posedge clk);
    if (!rst) begin
      model_reset();
    end else if (load) begin
      if (exp_q.size() > 0) begin
        void'(exp_q.pop_front());
        void'(sel_q.pop_front());
      end
      if (g >= 0) begin
        exp_q.push_back(in_data[g*WIDTH +: WIDTH]);
        sel_q.push_back(g);
        last_data = in_data[g*WIDTH +: WIDTH];
        last_sel  = g;
        if (!fen) m_ptr = (g + 1) % N;
      end
    end
    #1;
    check_outputs();
  endtask

  initial begin
    logic [WIDTH-1:0] words [4];
    words[0] = 32'hAAAA; words[1] = 32'hBBBB; words[2] = 32'hCCCC; words[3] = 32'hDDDD;
    reset = 1'b0; in_valid = '0; in_data = '0; out_ready = 1'b0;
    force_en = 1'b0; force_sel = '0;
    model_reset();

    // Reset held with all channels valid, then idle release.
    in_data = {32'hDDDD, 32'hCCCC, 32'hBBBB, 32'hAAAA};
    repeat (3) begin
      cycle(1'b0, 4'b1111, 1'b1, 1'b0, 2'd0);
      check("rst_ready", ir_seen, 4'b0000);
      check("rst_valid", out_valid, 1'b0);
    end
    repeat (2) cycle(1'b1, 4'b0000, 1'b1, 1'b0, 2'd0);
    check("idle_valid", out_valid, 1'b0);
    check("idle_data", out_data, 32'h0);
    check("idle_sel", out_sel, 2'd0);

    // Round-robin fairness with every channel valid.
    for (int k = 0; k < 6; k++) begin
      cycle(1'b1, 4'b1111, 1'b1, 1'b0, 2'd0);
      check("rr_sel", out_sel, k % 4);
      check("rr_data", out_data, words[k % 4]);
    end

    // Backpressure on channel 2.
    cycle(1'b0, 4'b0000, 1'b1, 1'b0, 2'd0);
    in_data[2*WIDTH +: WIDTH] = 32'h1234;
    cycle(1'b1, 4'b0100, 1'b0, 1'b0, 2'd0);
    check("bp_first_data", out_data, 32'h1234);
    check("bp_first_sel", out_sel, 2'd2);
    repeat (4) begin
      cycle(1'b1, 4'b0100, 1'b0, 1'b0, 2'd0);
      check("bp_ready", ir_seen, 4'b0000);
      check("bp_hold_valid", out_valid, 1'b1);
      check("bp_hold_data", out_data, 32'h1234);
    end
    in_data[2*WIDTH +: WIDTH] = 32'h5678;
    cycle(1'b1, 4'b0100, 1'b1, 1'b0, 2'd0);
    check("bp_accept", ir_seen, 4'b0100);
    check("bp_nobubble", out_valid, 1'b1);
    check("bp_next_data", out_data, 32'h5678);

    // Pointer now 3: skip to channel 0 with wrap, then on to channel 2.
    cycle(1'b1, 4'b0101, 1'b1, 1'b0, 2'd0);
    check("wrap_grant0", ir_seen, 4'b0001);
    cycle(1'b1, 4'b0101, 1'b1, 1'b0, 2'd0);
    check("wrap_grant2", ir_seen, 4'b0100);

    // Force mode: only channel 1, pointer (3) untouched.
    repeat (2) begin
      cycle(1'b1, 4'b1111, 1'b1, 1'b1, 2'd1);
      check("force_grant", ir_seen, 4'b0010);
      check("force_sel", out_sel, 2'd1);
    end
    cycle(1'b1, 4'b1111, 1'b1, 1'b0, 2'd0);
    check("force_ptr_kept", ir_seen, 4'b1000);
    cycle(1'b1, 4'b1101, 1'b1, 1'b1, 2'd1);
    check("force_nogrant", ir_seen, 4'b0000);
    check("force_drain", out_valid, 1'b0);

    // Asynchronous reset between edges while a word is pending.
    cycle(1'b1, 4'b0010, 1'b0, 1'b0, 2'd0);
    cycle(1'b1, 4'b0010, 1'b0, 1'b0, 2'd0);
    @(negedge clk);
    #2;
    reset = 1'b0;
    #1;
    check("arst_valid", out_valid, 1'b0);
    check("arst_data", out_data, 32'h0);
    check("arst_ready", in_ready, 4'b0000);
    model_reset();
    cycle(1'b0, 4'b1111, 1'b1, 1'b0, 2'd0);
    cycle(1'b1, 4'b1111, 1'b1, 1'b0, 2'd0);
    check("arst_first_grant", ir_seen, 4'b0001);
    check("arst_first_sel", out_sel, 2'd0);

    // Randomized traffic against the model.
    for (int n = 0; n < 400; n++) begin
      for (int c = 0; c < N; c++) in_data[c*WIDTH +: WIDTH] = $urandom;
      cycle(1'b1, 4'($urandom_range(0, 15)), $urandom_range(0, 3) != 0,
            $urandom_range(0, 4) == 0, 2'($urandom_range(0, 3)));
    end
    repeat (2) cycle(1'b1, 4'b0000, 1'b1, 1'b0, 2'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
